// File: rtl/upf_pkg.sv
// Constants shared by the upf approximate adder/subtractor family.
package upf_pkg;

    localparam logic SUB_CIN       = 1'b1;  // a - b = a + ~b + 1
    localparam logic SUB_DIS_CARRY = 1'b1;  // disabled block never borrows

    // Number of K-bit blocks in the lower half of an N-bit operand.
    function automatic int upf_m(input int n, input int k);
        return (n / 2) / k;
    endfunction

endpackage

// File: rtl/rca_block.sv
// Exact W-bit ripple-carry adder block used for every exact slice of the family.
module rca_block #(
    parameter int W = 4
) (
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    input  logic         c_i,
    output logic [W-1:0] s_o,
    output logic         c_o
);

    assign {c_o, s_o} = {1'b0, a_i} + {1'b0, b_i} + {{W{1'b0}}, c_i};

endmodule

// File: rtl/upfsub_pipe.sv
// Two-stage valid/ready approximate subtractor with per-transaction block enables.
// Optional `UPFSUB_ERR_EN adds err_o = exact - approx, aligned with d_o.
module upfsub_pipe
    import upf_pkg::*;
#(
    parameter  int N = 32,
    parameter  int K = 4,
    localparam int M = upf_m(N, K)
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         in_valid_i,
    output logic         in_ready_o,
    input  logic [N-1:0] a_i,
    input  logic [N-1:0] b_i,
    input  logic [M-1:0] cfg_i,
    output logic         out_valid_o,
    input  logic         out_ready_i,
    output logic [N-1:0] d_o,
    output logic         borrow_o
`ifdef UPFSUB_ERR_EN
    ,
    output logic [N-1:0] err_o
`endif
);

    localparam int H = N / 2;

    logic         s1_valid_q;
    logic [H-1:0] s1_dlo_q;
    logic         s1_c_q;
    logic [H-1:0] s1_ahi_q;
    logic [H-1:0] s1_nbhi_q;
    logic         out_valid_q;
    logic [N-1:0] d_q;
    logic         borrow_q;

    logic s2_free, s1_adv, accept;

    assign s2_free    = ~out_valid_q | out_ready_i;
    assign s1_adv     = s1_valid_q & s2_free;
    assign in_ready_o = ~s1_valid_q | s2_free;
    assign accept     = in_valid_i & in_ready_o;

    // Lower half: chain of K-bit blocks; a disabled block forces zero bits and no borrow.
    logic [M:0]   carry;
    logic [H-1:0] dlo_d;

    assign carry[0] = SUB_CIN;

    genvar i;
    generate
        for (i = 0; i < M; i++) begin : g_lo
            logic [K-1:0] s;
            logic         co;

            rca_block #(.W(K)) u_blk (
                .a_i (a_i[i*K +: K]),
                .b_i (~b_i[i*K +: K]),
                .c_i (carry[i]),
                .s_o (s),
                .c_o (co)
            );

            assign dlo_d[i*K +: K] = cfg_i[i] ? s  : '0;
            assign carry[i+1]      = cfg_i[i] ? co : SUB_DIS_CARRY;
        end
    endgenerate

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            s1_valid_q <= 1'b0;
            s1_dlo_q   <= '0;
            s1_c_q     <= 1'b0;
            s1_ahi_q   <= '0;
            s1_nbhi_q  <= '0;
        end else if (accept) begin
            s1_valid_q <= 1'b1;
            s1_dlo_q   <= dlo_d;
            s1_c_q     <= carry[M];
            s1_ahi_q   <= a_i[N-1:H];
            s1_nbhi_q  <= ~b_i[N-1:H];
        end else if (s1_adv) begin
            s1_valid_q <= 1'b0;
        end
    end

    // Upper half is always exact, fed from the stage-1 registers.
    logic [H-1:0] dhi_d;
    logic         cout_d;
    logic [N-1:0] d_d;
    logic         borrow_d;

    rca_block #(.W(H)) u_hi (
        .a_i (s1_ahi_q),
        .b_i (s1_nbhi_q),
        .c_i (s1_c_q),
        .s_o (dhi_d),
        .c_o (cout_d)
    );

    assign d_d      = {dhi_d, s1_dlo_q};
    assign borrow_d = ~cout_d;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            out_valid_q <= 1'b0;
            d_q         <= '0;
            borrow_q    <= 1'b0;
        end else if (s1_adv) begin
            out_valid_q <= 1'b1;
            d_q         <= d_d;
            borrow_q    <= borrow_d;
        end else if (out_ready_i) begin
            out_valid_q <= 1'b0;
        end
    end

    assign out_valid_o = out_valid_q;
    assign d_o         = d_q;
    assign borrow_o    = borrow_q;

`ifdef UPFSUB_ERR_EN
    logic [N-1:0] s1_exact_q;
    logic [N-1:0] err_q;
    logic [N-1:0] err_d;

    assign err_d = s1_exact_q - d_d;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            s1_exact_q <= '0;
            err_q      <= '0;
        end else begin
            if (accept) s1_exact_q <= a_i - b_i;
            if (s1_adv) err_q      <= err_d;
        end
    end

    assign err_o = err_q;
`endif

endmodule

// File: tb/tb_upfsub_pipe.sv
// Self-checking bench for upfsub_pipe (N=32, K=4): vector table, stall/reset sequences, random stream.
module tb_upfsub_pipe;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] a, b;
    logic [3:0]  cfg;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] d;
    logic        borrow;
`ifdef UPFSUB_ERR_EN
    logic [31:0] err;
`endif

    upfsub_pipe #(.N(32), .K(4)) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .a_i         (a),
        .b_i         (b),
        .cfg_i       (cfg),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .d_o         (d),
        .borrow_o    (borrow)
`ifdef UPFSUB_ERR_EN
        ,
        .err_o       (err)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  cfg;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] d;
        logic        br;
        logic [31:0] err;
    } vec_t;

    typedef struct {
        logic [31:0] d;
        logic        br;
        logic [31:0] err;
    } exp_t;

    int   total = 0;
    int   bad   = 0;
    int   npop  = 0;
    exp_t q[$];
    logic        hold_chk = 1'b0;
    logic [31:0] hold_d;
    logic        hold_br;
    logic        last_acc;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%h want=%h", nm, act, exp);
        end
    endtask

    // Reference: plain borrow-chain subtraction per block; a disabled block yields 0 and
    // swallows any incoming borrow, so the chain restarts fresh above it.
    function automatic exp_t model(input logic [31:0] av, input logic [31:0] bv, input logic [3:0] c);
        exp_t e;
        int   bor = 0;
        int   v;
        e.d = '0;
        for (int k = 0; k < 4; k++) begin
            if (c[k]) begin
                v = int'(av[k*4 +: 4]) - int'(bv[k*4 +: 4]) - bor;
                e.d[k*4 +: 4] = 4'(v);
                bor = (v < 0) ? 1 : 0;
            end else begin
                bor = 0;
            end
        end
        v = int'(av[31:16]) - int'(bv[31:16]) - bor;
        e.d[31:16] = 16'(v);
        e.br  = (v < 0);
        e.err = (av - bv) - e.d;
        return e;
    endfunction

    // One cycle: drive at negedge, sample settled outputs, let the next posedge act.
    task automatic step(input logic v, input logic [31:0] av, input logic [31:0] bv,
                        input logic [3:0] c, input logic rdy);
        exp_t e;
        @(negedge clk);
        in_valid = v; a = av; b = bv; cfg = c; out_ready = rdy;
        #1;
        if (hold_chk) begin
            chk("hold_valid", 32'(out_valid), 32'd1);
            chk("hold_d", d, hold_d);
            chk("hold_borrow", 32'(borrow), 32'(hold_br));
        end
        if (out_valid && out_ready) begin
            if (q.size() == 0) begin
                chk("unexpected_out", 32'(out_valid), 32'd0);
            end else begin
                e = q.pop_front();
                npop++;
                chk("stream_d", d, e.d);
                chk("stream_borrow", 32'(borrow), 32'(e.br));
`ifdef UPFSUB_ERR_EN
                chk("stream_err", err, e.err);
`endif
            end
        end
        hold_chk = out_valid && !out_ready;
        hold_d   = d;
        hold_br  = borrow;
        last_acc = v && in_ready;
        if (last_acc) q.push_back(model(av, bv, c));
    endtask

    vec_t vt[6];
    int   idx;
    int   p0;
    logic [31:0] ba[4];
    logic [31:0] bb[4];

    initial begin
        vt[0] = '{4'b1111, 32'h0000_1234, 32'h0000_0234, 32'h0000_1000, 1'b0, 32'h0000_0000};
        vt[1] = '{4'b1111, 32'h0000_0000, 32'h0000_0001, 32'hFFFF_FFFF, 1'b1, 32'h0000_0000};
        vt[2] = '{4'b0000, 32'h0005_1234, 32'h0001_0034, 32'h0004_0000, 1'b0, 32'h0000_1200};
        vt[3] = '{4'b1110, 32'h0000_0013, 32'h0000_0005, 32'h0000_0010, 1'b0, 32'hFFFF_FFFE};
        vt[4] = '{4'b1111, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 1'b0, 32'h0000_0000};
        vt[5] = '{4'b0101, 32'h0000_0000, 32'h0000_00FF, 32'h0000_0001, 1'b0, 32'hFFFF_FF00};

        rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; cfg = '0; out_ready = 1'b1;
        #12;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_d", d, 32'd0);
        chk("rst_borrow", 32'(borrow), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        @(negedge clk); rst_n = 1'b1;
        #1 chk("post_rst_in_ready", 32'(in_ready), 32'd1);

        // Directed vectors with latency check: presented before edge E1, visible after E2.
        foreach (vt[j]) begin
            @(negedge clk);
            in_valid = 1'b1; a = vt[j].a; b = vt[j].b; cfg = vt[j].cfg; out_ready = 1'b1;
            #1 chk("vec_in_ready", 32'(in_ready), 32'd1);
            @(negedge clk);
            in_valid = 1'b0; a = '0; b = '0; cfg = '0;
            #1 chk("vec_not_early", 32'(out_valid), 32'd0);
            @(negedge clk);
            #1;
            chk("vec_valid", 32'(out_valid), 32'd1);
            chk("vec_d", d, vt[j].d);
            chk("vec_borrow", 32'(borrow), 32'(vt[j].br));
`ifdef UPFSUB_ERR_EN
            chk("vec_err", err, vt[j].err);
`endif
        end
        step(1'b0, '0, '0, '0, 1'b1);

        // Backpressure: 4 back-to-back ops, downstream stalls for 3 cycles.
        for (int k = 0; k < 4; k++) begin
            ba[k] = 32'h1000_0000 * (k + 1) + 32'h0000_0ABC;
            bb[k] = 32'h0000_1111 * (k + 3);
        end
        idx = 0;
        p0  = npop;
        for (int c = 0; c < 30; c++) begin
            if (idx < 4) step(1'b1, ba[idx], bb[idx], 4'b1011, (c >= 5));
            else         step(1'b0, '0, '0, '0, (c >= 5));
            if (last_acc) idx++;
            if (c == 2) begin
                chk("bp_in_ready_low", 32'(in_ready), 32'd0);
                chk("bp_captured", 32'(idx), 32'd2);
            end
            if (idx == 4 && q.size() == 0 && !out_valid) break;
        end
        chk("bp_all_out", 32'(npop - p0), 32'd4);

        // Reset with both stages occupied.
        step(1'b1, 32'h0000_0777, 32'h0000_0111, 4'b1111, 1'b0);
        step(1'b1, 32'h0000_0888, 32'h0000_0222, 4'b1111, 1'b0);
        step(1'b0, '0, '0, '0, 1'b0);
        chk("mid_out_valid", 32'(out_valid), 32'd1);
        chk("mid_s1_full", 32'(in_ready), 32'd0);
        rst_n = 1'b0;
        #1;
        chk("arst_out_valid", 32'(out_valid), 32'd0);
        chk("arst_d", d, 32'd0);
        chk("arst_in_ready", 32'(in_ready), 32'd1);
        q.delete();
        hold_chk = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        for (int c = 0; c < 5; c++) step(1'b0, '0, '0, '0, 1'b1);
        chk("no_stale", 32'(out_valid), 32'd0);

        // Random stream with random backpressure against the reference model.
        for (int c = 0; c < 400; c++)
            step(1'($urandom_range(0, 1)), $urandom, $urandom, 4'($urandom),
                 ($urandom_range(0, 3) != 0));
        for (int c = 0; c < 20 && (q.size() != 0 || out_valid); c++)
            step(1'b0, '0, '0, '0, 1'b1);
        chk("drain_empty", 32'(q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
